// File: rtl/fir4_out_fmt_if.sv
// Output-side bus of the FIR formatter: the raw FIR sum going in, and the
// buffered, formatted sample stream coming out.
//
// Handshake: y_valid/y_ready. An entry moves to the consumer exactly at a
// rising clk edge where y_valid and y_ready are both high. y_valid depends
// only on FIFO occupancy, never on y_ready. While y_valid is high and no
// transfer happens, y and y_sat hold. y_ready is ignored while y_valid is low.
interface fir4_out_fmt_if #(
  parameter int w     = 16,
  parameter int DEPTH = 4
);
  logic [w+1:0]            s;
  logic [w-1:0]            y;
  logic                    y_sat;
  logic                    y_valid;
  logic                    y_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;

  // Producer/consumer side (drives the sum and the accept).
  modport master (
    output s,
    output y_ready,
    input  y,
    input  y_sat,
    input  y_valid,
    input  level,
    input  overflow
  );

  // Formatter side.
  modport slave (
    input  s,
    input  y_ready,
    output y,
    output y_sat,
    output y_valid,
    output level,
    output overflow
  );
endinterface

// File: rtl/fir4_out_fmt.sv
// FIR output formatter: rounds and shifts the w+2 bit FIR sum down to w bits
// with saturation, discards the first WARM samples after reset while the
// filter taps fill, and buffers results in a small FIFO for the consumer.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fir4_out_fmt #(
  parameter int w     = 16,
  parameter int SH    = 2,
  parameter int DEPTH = 4,
  parameter int WARM  = 5
) (
  input  logic          clk,
  input  logic          reset,
  fir4_out_fmt_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (WARM > 0) ? $clog2(WARM + 1) : 1;
  localparam int SW = w + 3;
  // Half an output LSB for round-half-up; zero when there is no shift.
  localparam logic [SW-1:0] RND  = SW'((1 << SH) >> 1);
  localparam logic [SW-1:0] YMAX = {3'b000, {w{1'b1}}};

  logic [SW-1:0] sum;
  logic [SW-1:0] r;
  logic [w-1:0]  fmt_y;
  logic          fmt_sat;

  logic [WW-1:0] warm_cnt;
  logic          warm_done;

  logic [w-1:0]  mem_y   [DEPTH];
  logic          mem_sat [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level_q;
  logic          overflow_q;

  logic          empty;
  logic          full;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          drop;

  // Round, shift and saturate the incoming sum at full width.
  always_comb begin
    sum     = {1'b0, bus.s} + RND;
    r       = sum >> SH;
    fmt_sat = (r > YMAX);
    fmt_y   = fmt_sat ? {w{1'b1}} : r[w-1:0];
  end

  assign warm_done = (warm_cnt == WW'(WARM));

  // Count reset-free edges until the warm-up window has passed, then park.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // A full FIFO still accepts a sample when the head leaves on the same edge.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == (AW+1)'(DEPTH));
    push_req = warm_done;
    pop      = !empty && bus.y_ready;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // FIFO storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_y[i]   <= '0;
        mem_sat[i] <= 1'b0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_y[wr_ptr]   <= fmt_y;
        mem_sat[wr_ptr] <= fmt_sat;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.y        = mem_y[rd_ptr];
  assign bus.y_sat    = mem_sat[rd_ptr];
  assign bus.y_valid  = !empty;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/fir4_out_fmt.md
FIR4_OUT_FMT -- requirements
Module: fir4_out_fmt

Interface
REQ-001: Parameter w, default 16, sample width; the upstream FIR sum input is w+2 bits.
REQ-002: Parameter SH, default 2, right-shift applied to the sum; legal values are 0..2.
REQ-003: Parameter DEPTH, default 4, output FIFO entries; it SHALL be a power of two and at least 2.
REQ-004: Parameter WARM, default 5, number of post-reset samples to discard.
REQ-005: clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006: reset  in  1  synchronous, active-high reset.
REQ-007: s  in  w+2  unsigned FIR sum; a new value arrives every clk cycle.
REQ-008: y  out  w  formatted sample at the FIFO head.
REQ-009: y_sat  out  1  saturation flag stored with the head entry.
REQ-010: y_valid  out  1  high when the FIFO holds at least one entry.
REQ-011: y_ready  in  1  consumer accept; a pop occurs when y_valid and y_ready are both high at a rising edge.
REQ-012: level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013: overflow  out  1  sticky flag indicating a sample was dropped.

Function
REQ-014: Formatting SHALL be r = (s + (SH>0 ? 2^(SH-1) : 0)) >> SH, computed at w+3 bits with no intermediate truncation (round half up).
REQ-015: If r > 2^w-1, then y SHALL be 2^w-1 and sat SHALL be 1; otherwise y = r[w-1:0] and sat = 0.
REQ-016: A warm-up counter SHALL count rising edges with reset low; samples at the first WARM such edges SHALL be discarded with no push and no overflow.
REQ-017: Once warm-up is complete, the formatted s SHALL be pushed into the FIFO at every rising edge.
REQ-018: Latency SHALL be one edge: s present before edge N is visible at y with y_valid=1 after edge N, provided the FIFO was empty.
REQ-019: Entries SHALL leave the FIFO in order: {y, y_sat} at the head, read pointer advancing on each pop.
REQ-020: When the FIFO is full with no pop: the incoming sample SHALL be dropped, the contents SHALL be unchanged, and overflow SHALL be set to 1.
REQ-021: When the FIFO is full and a pop occurs on the same edge: the push SHALL succeed, level SHALL stay at DEPTH, and overflow SHALL be unchanged.
REQ-022: When the FIFO is empty, y_ready SHALL be ignored: no pop occurs and pointers do not move.
REQ-023: Under simultaneous push and pop with level not full, level SHALL be unchanged.
REQ-024: Pointers SHALL wrap modulo DEPTH.
REQ-025: level SHALL update on the same edge as the push or pop that changes it.
REQ-026: overflow SHALL clear only on reset.
REQ-027: While y_valid=1 and no pop occurs, y and y_sat SHALL hold steady.

Reset
REQ-028: While reset=1 at an edge, the block SHALL clear pointers, level, all FIFO storage, overflow, and the warm-up counter.
REQ-029: Outputs after reset SHALL be y=0, y_sat=0, y_valid=0, level=0, overflow=0.
REQ-030: Reset asserted mid-stream SHALL discard all buffered entries and restart warm-up.
REQ-031: The first push after reset SHALL occur at the (WARM+1)th edge with reset low.

Verification (w=16, DEPTH=4, WARM=5)
REQ-032: SH=2, constant s=400, y_ready=1 -> nothing is valid for 5 edges; then y=100, y_sat=0, y_valid=1 every cycle, and level stays at 1.
REQ-033: SH=2, s=5 then s=6 then s=0x3FFFC -> y=1, then 2, then 0xFFFF with y_sat=0.
REQ-034: SH=1, s=0x3FFFC -> y=0xFFFF with y_sat=1; SH=0, s=0x10000 -> y=0xFFFF with y_sat=1; SH=0, s=0xFFFF -> y_sat=0.
REQ-035: After warm-up, y_ready=0 with s=4,8,12,...,40 (SH=2) -> level=4 and overflow=1; draining then yields y=1,2,3,4, overflow stays 1, and the final level is 0.
REQ-036: Full FIFO with y_ready=1 for one edge -> one pop and one push, level=4, and overflow does not newly set.
REQ-037: Reset pulsed for one edge at level=3 -> level=0, y_valid=0, overflow=0; the next push occurs 5 edges later.
